// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common data bus arbiter: ROB index width,
// requester slot numbering and the round-robin pointer advance.
package cdb_arbiter_pkg;

  localparam int ROB_WIDTH_BIT = 4;

  localparam int CDB_SRC_ALU   = 0;
  localparam int CDB_SRC_LSB   = 1;
  localparam int CDB_SRC_SPARE = 2;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr wins,
// wrapping modulo NUM_REQ. Grant is one-hot or zero.
module rr_pick
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               any_grant
);

  logic [SRC_W-1:0] idx;

  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = SRC_W'((int'(ptr) + k) % NUM_REQ);
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the registered CDB between ALU, LSB and a spare
// producer; each producer owns a one-entry holding slot behind valid/ready.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int ROB_ID_W = ROB_WIDTH_BIT,
  parameter int SRC_W    = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         clear_flag,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ROB_ID_W-1:0]  req_rob_id,
  input  logic [NUM_REQ*32-1:0]        req_val,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         cdb_valid,
  output logic [ROB_ID_W-1:0]          cdb_rob_id,
  output logic [31:0]                  cdb_val,
  output logic [SRC_W-1:0]             cdb_src
);

  logic [NUM_REQ-1:0]  hold_v;
  logic [ROB_ID_W-1:0] hold_id  [NUM_REQ];
  logic [31:0]         hold_val [NUM_REQ];
  logic [SRC_W-1:0]    ptr;
  logic [NUM_REQ-1:0]  grant;
  logic                any_grant;
  logic [SRC_W-1:0]    win_idx;
  logic [NUM_REQ-1:0]  accept;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_pick (
    .req       (hold_v),
    .ptr       (ptr),
    .grant     (grant),
    .any_grant (any_grant)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_idx = SRC_W'(i);
    end
  end

  // A slot being broadcast this cycle may reload in the same cycle.
  assign req_ready = {NUM_REQ{rdy_in & ~clear_flag & ~rst_in}} & (~hold_v | grant);
  assign accept    = req_valid & req_ready;

  // Stage: holding-slot payload (accept already folds in rdy/flush/reset)
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        hold_id[i]  <= req_rob_id[i*ROB_ID_W +: ROB_ID_W];
        hold_val[i] <= req_val[i*32 +: 32];
      end
    end
  end

  // Stage: slot valids, pointer and registered CDB broadcast
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hold_v     <= '0;
      ptr        <= '0;
      cdb_valid  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_val    <= '0;
      cdb_src    <= '0;
    end else if (rdy_in) begin
      if (clear_flag) begin
        hold_v    <= '0;
        ptr       <= '0;
        cdb_valid <= 1'b0;
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (accept[i])     hold_v[i] <= 1'b1;
          else if (grant[i]) hold_v[i] <= 1'b0;
        end
        if (any_grant) begin
          cdb_valid  <= 1'b1;
          cdb_rob_id <= hold_id[win_idx];
          cdb_val    <= hold_val[win_idx];
          cdb_src    <= win_idx;
          ptr        <= SRC_W'(rr_next(int'(win_idx), NUM_REQ));
        end else begin
          cdb_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts are queued when driven
// and popped by a monitor whenever a fresh broadcast appears on the CDB.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int RW = ROB_WIDTH_BIT;
  localparam int SW = 2;

  typedef struct packed {
    logic [RW-1:0] id;
    logic [31:0]   val;
    logic [SW-1:0] src;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rdy = 1'b1;
  logic            clr = 1'b0;
  logic [N-1:0]    vld = '0;
  logic [N*RW-1:0] ids = '0;
  logic [N*32-1:0] vals = '0;
  logic [N-1:0]    ready;
  logic            cdb_valid;
  logic [RW-1:0]   cdb_rob_id;
  logic [31:0]     cdb_val;
  logic [SW-1:0]   cdb_src;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  logic rdy_last = 1'b0;

  cdb_arbiter #(.NUM_REQ(N), .ROB_ID_W(RW), .SRC_W(SW)) dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .rdy_in     (rdy),
    .clear_flag (clr),
    .req_valid  (vld),
    .req_rob_id (ids),
    .req_val    (vals),
    .req_ready  (ready),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_val    (cdb_val),
    .cdb_src    (cdb_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [RW-1:0] id, input logic [31:0] val);
    vld[i]            = v;
    ids[i*RW +: RW]   = id;
    vals[i*32 +: 32]  = val;
  endtask

  task automatic push(input logic [RW-1:0] id, input logic [31:0] val, input int src);
    exp_t e;
    e.id  = id;
    e.val = val;
    e.src = SW'(src);
    sb.push_back(e);
  endtask

  // A broadcast is new only if the previous edge was not stalled.
  always @(posedge clk) rdy_last <= rdy && !rst;

  always @(negedge clk) begin
    if (mon_en && rdy_last && cdb_valid) begin
      if (sb.size() == 0) begin
        chk("sb_extra_valid", 64'(cdb_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_id",  64'(cdb_rob_id), 64'(e.id));
        chk("sb_val", 64'(cdb_val),    64'(e.val));
        chk("sb_src", 64'(cdb_src),    64'(e.src));
      end
    end
  end

  initial begin
    // Reset with all requesters pending
    for (int i = 0; i < N; i++) set_req(i, 1'b1, RW'(i + 1), 32'hF0 + i);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_valid", 64'(cdb_valid), 64'd0);
      chk("rst_ready", 64'(ready), 64'd0);
    end
    chk("rst_id",  64'(cdb_rob_id), 64'd0);
    chk("rst_val", 64'(cdb_val), 64'd0);
    chk("rst_src", 64'(cdb_src), 64'd0);
    rst = 1'b0;
    vld = '0;
    mon_en = 1'b1;
    step();
    chk("idle_valid", 64'(cdb_valid), 64'd0);

    // Single source streaming on ALU
    for (int k = 1; k <= 3; k++) begin
      set_req(CDB_SRC_ALU, 1'b1, RW'(k), 32'(k * 'h11));
      push(RW'(k), 32'(k * 'h11), CDB_SRC_ALU);
      #1 chk("stream_ready", 64'(ready[0]), 64'd1);
      step();
      if (k > 1) chk("stream_cdb_id", 64'(cdb_rob_id), 64'(k - 1));
    end
    vld = '0;
    step();
    chk("stream_last", 64'(cdb_rob_id), 64'd3);
    step();
    chk("stream_done", 64'(cdb_valid), 64'd0);

    // Flush pulse brings the pointer back to 0
    clr = 1'b1;
    #1 chk("clr_ready", 64'(ready), 64'd0);
    step();
    clr = 1'b0;

    // Three-way contention
    set_req(0, 1'b1, 4'd4, 32'h44);
    set_req(1, 1'b1, 4'd5, 32'h55);
    set_req(2, 1'b1, 4'd6, 32'h66);
    push(4'd4, 32'h44, 0);
    push(4'd5, 32'h55, 1);
    push(4'd6, 32'h66, 2);
    #1 chk("c3_ready", 64'(ready), 64'b111);
    step();
    vld = '0;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("c3_src", 64'(cdb_src), 64'(s));
      chk("c3_valid", 64'(cdb_valid), 64'd1);
    end
    step();
    chk("c3_done", 64'(cdb_valid), 64'd0);

    // Reload src1 and src2 together, pointer back at 0
    set_req(1, 1'b1, 4'd11, 32'hB1);
    set_req(2, 1'b1, 4'd14, 32'hE2);
    push(4'd11, 32'hB1, 1);
    push(4'd14, 32'hE2, 2);
    step();
    vld = '0;
    step();
    chk("c2_first", 64'(cdb_src), 64'd1);
    step();
    chk("c2_second", 64'(cdb_src), 64'd2);
    step();
    chk("c2_done", 64'(cdb_valid), 64'd0);

    // Backpressure: src1 holds id 7 behind src0, then offers id 8
    set_req(0, 1'b1, 4'd3, 32'h30);
    set_req(1, 1'b1, 4'd7, 32'h77);
    push(4'd3, 32'h30, 0);
    push(4'd7, 32'h77, 1);
    step();
    vld = '0;
    set_req(1, 1'b1, 4'd8, 32'h88);
    #1 chk("bp_blocked", 64'(ready[1]), 64'd0);
    step();
    chk("bp_win0", 64'(cdb_rob_id), 64'd3);
    #1 chk("bp_grant_ready", 64'(ready[1]), 64'd1);
    push(4'd8, 32'h88, 1);
    step();
    vld = '0;
    chk("bp_id7", 64'(cdb_rob_id), 64'd7);
    step();
    chk("bp_id8", 64'(cdb_rob_id), 64'd8);
    step();
    chk("bp_done", 64'(cdb_valid), 64'd0);

    // Flush discards held ids 9 and 10
    set_req(0, 1'b1, 4'd9,  32'h99);
    set_req(1, 1'b1, 4'd10, 32'hAA);
    step();
    vld = '0;
    clr = 1'b1;
    #1 chk("fl_ready", 64'(ready), 64'd0);
    step();
    clr = 1'b0;
    chk("fl_valid", 64'(cdb_valid), 64'd0);
    step();
    chk("fl_quiet", 64'(cdb_valid), 64'd0);
    set_req(1, 1'b1, 4'd5, 32'h51);
    set_req(2, 1'b1, 4'd6, 32'h62);
    push(4'd5, 32'h51, 1);
    push(4'd6, 32'h62, 2);
    step();
    vld = '0;
    step();
    chk("fl_ptr0", 64'(cdb_src), 64'd1);
    step();
    chk("fl_next", 64'(cdb_src), 64'd2);
    step();

    // Stall with id 12 on the bus and id 13 waiting in src2
    set_req(0, 1'b1, 4'd12, 32'hC0);
    set_req(2, 1'b1, 4'd13, 32'hD2);
    push(4'd12, 32'hC0, 0);
    push(4'd13, 32'hD2, 2);
    step();
    vld = '0;
    step();
    chk("st_pre", 64'(cdb_rob_id), 64'd12);
    rdy = 1'b0;
    set_req(1, 1'b1, 4'd2, 32'h21);
    for (int c = 0; c < 3; c++) begin
      clr = (c == 1);
      #1 chk("st_ready", 64'(ready), 64'd0);
      step();
      chk("st_valid", 64'(cdb_valid), 64'd1);
      chk("st_id", 64'(cdb_rob_id), 64'd12);
    end
    clr = 1'b0;
    vld = '0;
    rdy = 1'b1;
    step();
    chk("st_resume_id", 64'(cdb_rob_id), 64'd13);
    chk("st_resume_src", 64'(cdb_src), 64'd2);
    step();
    chk("st_done", 64'(cdb_valid), 64'd0);
    step();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Round-robin arbiter that shares the single common data bus (CDB) between result producers: ALU, LSB, and a spare port. Each producer hands one result (ROB id and value) to the arbiter through a valid/ready handshake into a one-entry holding slot. The arbiter broadcasts at most one result per cycle on a registered CDB. The CDB feeds the ROB, which supplies the register file's rs1/rs2 ready/value lookups.

Parameters:
NUM_REQ, 3, number of requesters (index 0 = ALU, 1 = LSB, 2 = spare); legal range 2..4
ROB_ID_W, `ROB_WIDTH_BIT, ROB index width; taken from const.v
SRC_W, 2, width of the winning-source index; must satisfy 2^SRC_W >= NUM_REQ

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, synchronous, active-high
rdy_in  input  1  global ready; low freezes the block
clear_flag  input  1  misprediction flush from ROB
req_valid  input  NUM_REQ  per-requester result valid
req_rob_id  input  NUM_REQ*ROB_ID_W  packed ROB ids; requester i occupies bits [i*ROB_ID_W +: ROB_ID_W]
req_val  input  NUM_REQ*32  packed result values; requester i occupies bits [i*32 +: 32]
req_ready  output  NUM_REQ  per-requester accept; combinational
cdb_valid  output  1  broadcast valid, registered
cdb_rob_id  output  ROB_ID_W  broadcast ROB id, registered
cdb_val  output  32  broadcast value, registered
cdb_src  output  SRC_W  index of the winning requester, registered

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is synchronous and active-high.
- Reset values: hold_v[*]=0, ptr=0, cdb_valid=0, cdb_rob_id=0, cdb_val=0, cdb_src=0.
- Per-requester state: hold_v, hold_id, hold_val.
- Grant logic (combinational, from current state only):
  - Scan hold_v starting at ptr, wrapping modulo NUM_REQ.
  - The first set slot wins; grant is one-hot or zero.
- Ready rule: req_ready[i] = rdy_in & !clear_flag & (!hold_v[i] | grant[i]).
  - A slot that is being broadcast this cycle can reload in the same cycle.
  - Each source can therefore sustain 1 result/cycle when it is the only one active.
- Accept rule: req_valid[i] & req_ready[i] at a clock edge loads hold_v[i]=1, hold_id, hold_val.
  - req_valid without req_ready means the requester must hold its data stable. The arbiter never drops an unaccepted request except on clear_flag.
- Broadcast at each edge with rdy_in=1 and clear_flag=0:
  - If a winner w exists: cdb_valid<=1, cdb_rob_id<=hold_id[w], cdb_val<=hold_val[w], cdb_src<=w.
  - hold_v[w]<=0, unless it is reloaded in the same edge.
  - ptr<=(w+1) mod NUM_REQ.
  - If there is no winner: cdb_valid<=0 and ptr is unchanged.
  - cdb_rob_id, cdb_val and cdb_src keep their last values while cdb_valid=0.
- Latency: a request accepted at edge E appears on the CDB after edge E+1 at the earliest. Under full contention from all NUM_REQ sources the worst-case wait is NUM_REQ cycles.
- Fairness: a source that loses arbitration is served within NUM_REQ-1 further broadcasts.
- clear_flag=1 (with rdy_in=1): all hold_v<=0, cdb_valid<=0, ptr<=0.
  - req_ready is 0, so nothing is accepted.
  - Higher priority than any accept or broadcast in the same cycle.
- rdy_in=0: all registers hold, including cdb_valid, and req_ready=0. clear_flag is ignored while rdy_in=0.
- rst_in has priority over rdy_in and clear_flag. Reset mid-operation discards held results; pending requesters see req_ready=0 during reset.
- Simultaneous events:
  - A reload and a grant on the same slot in one edge: the new data is stored and hold_v stays 1.
  - Two sources loaded in the same edge: both are stored, then served in round-robin order.
- Width: the ROB id and the 32-bit value pass through unmodified; no arithmetic.

Decomposition:
- const.v (shared):
  - ROB_WIDTH_BIT.
  - Requester-index constants: CDB_SRC_ALU=0, CDB_SRC_LSB=1, CDB_SRC_SPARE=2.
- Sub-module rr_pick:
  - Inputs: NUM_REQ request bits and ptr.
  - Outputs: one-hot grant and any_grant; purely combinational.
  - Instantiated once; reusable by the RS issue selector.
- Holding slots and CDB registers stay in cdb_arbiter.

Test Plan:
- Reset:
  - Stimulus: rst_in=1 for 2 cycles with req_valid=3'b111.
  - Required: cdb_valid=0, req_ready=0, and after reset cdb_rob_id=0, cdb_val=0.
- Single source streaming:
  - Stimulus: ALU presents ids 1,2,3 on consecutive cycles with values 0x11,0x22,0x33.
  - Required: req_ready[0] stays 1; the CDB shows (1,0x11),(2,0x22),(3,0x33) on consecutive cycles starting one cycle after the first accept.
- Three-way contention:
  - Stimulus: all three sources load in the same edge (ids 4,5,6) with ptr=0.
  - Required: the CDB order is src 0,1,2 on consecutive cycles, then cdb_valid=0.
  - Then reload src1 and src2 together with ptr=0: src1 is broadcast first.
- Backpressure:
  - Stimulus: src1 holds id 7 and loses to src0; src1 presents id 8.
  - Required: req_ready[1]=0 that cycle; id 7 is broadcast next, id 8 is accepted in the grant cycle and broadcast one cycle later.
- Flush:
  - Stimulus: slots hold ids 9,10; assert clear_flag for 1 cycle.
  - Required: the next cycle has cdb_valid=0; ids 9 and 10 never appear; the following accept is granted from ptr=0.
- Stall:
  - Stimulus: drop rdy_in for 3 cycles while cdb_valid=1 with id 12 and src2 holds id 13.
  - Required: the outputs stay frozen at id 12 with req_ready=0; after rdy_in returns, id 13 is broadcast on the next edge.
